spi_write_scheduler: RTL and testbench
======================================

SPI_WRITE_SCHEDULER -- requirements
Module: spi_write_scheduler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range 2..255.
REQ-002 SHALL have parameter CS_GAP, default 2: minimum clk cycles cs_n stays high between frames, legal range 1..255.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester has a write pending.
REQ-006 SHALL have ports req0_addr/req1_addr  input  7  target register address.
REQ-007 SHALL have ports req0_data/req1_data  input  8  write data.
REQ-008 SHALL have ports req0_ready/req1_ready  output  1  one-cycle accept pulse.
REQ-009 SHALL have port cs_n  output  1  SPI chip select, active-low.
REQ-010 SHALL have port sclk  output  1  SPI clock, idle low, mode 0.
REQ-011 SHALL have port copi  output  1  SPI serial data out.
REQ-012 SHALL have port busy  output  1  high from accept until CS_GAP expires.
REQ-013 SHALL have port done  output  1  one-cycle pulse at frame completion (or skip).
REQ-014 SHALL have port err  output  1  one-cycle pulse when an illegal address is accepted.

Function
REQ-015 Frame SHALL be 16 bits, MSB first: bit15=1 (write), bits14:8=addr, bits7:0=data.
REQ-016 FSM states SHALL be IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP.
REQ-017 IDLE: grant only when at least one valid is high; the granted reqN_ready pulses for exactly one cycle; addr/data are captured that cycle.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not served last; after reset req0 wins the first tie.
REQ-019 A single valid requester SHALL be granted regardless of pointer; pointer updates on every grant.
REQ-020 Cycle after accept: cs_n=0, copi=bit15, enter SETUP for CLK_DIV cycles with sclk=0.
REQ-021 SHIFT_HI: sclk=1 for CLK_DIV cycles; SHIFT_LO: sclk=0 for CLK_DIV cycles; copi changes only on the cycle sclk falls.
REQ-022 After the 16th SHIFT_LO, cs_n SHALL rise, copi=0, done pulses once, and GAP lasts CS_GAP cycles.
REQ-023 cs_n SHALL be low for exactly 33*CLK_DIV cycles per frame.
REQ-024 Addresses above 4 SHALL be accepted with ready, generate no frame, and pulse err and done on the cycle after accept; the FSM then enters GAP.
REQ-025 Valid deasserted before grant SHALL be dropped without side effect; valid or data changes after accept SHALL NOT affect the frame in flight.
REQ-026 No ready pulse SHALL occur outside IDLE.

Reset
REQ-027 On rst low, immediately: cs_n=1, sclk=0, copi=0, ready=0, busy=0, done=0, err=0, FSM=IDLE, pointer=req0; any in-flight frame is aborted.
REQ-028 After rst release, the first grant SHALL occur no earlier than the first clk edge.

Configuration
REQ-029 Macro WRITE_SHADOW_EN SHALL, when defined, keep 8-bit shadow registers for addresses 0..4, reset to 0x00, updated on frame completion.
REQ-030 With WRITE_SHADOW_EN defined, a request whose data equals the shadow SHALL be accepted, send no frame, pulse done the next cycle, then enter GAP.
REQ-031 Without WRITE_SHADOW_EN, no shadow storage SHALL exist and every legal request generates a frame.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, frame-field widths, write-bit constant and max legal address (4).
REQ-033 Sub-module spi_frame_tx SHALL contain the shift register, bit counter and half-period divider; the top holds arbitration, FSM sequencing and shadow logic.

Verification
REQ-034 CLK_DIV=2, req0 addr=0x02 data=0xA5 -> copi sequence 1,0000010,10100101; cs_n low 66 cycles; single done.
REQ-035 req0 and req1 valid together from reset -> req0 served first, req1 second; ready pulses never overlap.
REQ-036 req0 addr=0x07 data=0x11 -> ready, err and done pulse, cs_n stays high.
REQ-037 Assert rst at bit 9 of a frame -> cs_n=1, sclk=0 same cycle; after release next frame complete and correct.
REQ-038 WRITE_SHADOW_EN: write addr=0x04 data=0x80 twice -> one frame, second request done-only, no cs_n activity.
REQ-039 Back-to-back requests, CS_GAP=3 -> cs_n high exactly 3 cycles between frames.

Source files
------------

// File: rtl/spi_write_scheduler_pkg.sv
// Shared types and constants for the SPI write scheduler.
package spi_write_scheduler_pkg;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FRAME_W    = 1 + ADDR_W + DATA_W;
    localparam int unsigned NUM_SHADOW = 5;

    localparam logic              WRITE_BIT = 1'b1;
    localparam logic [ADDR_W-1:0] MAX_ADDR  = 7'd4;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShiftHi,
        StShiftLo,
        StGap
    } state_e;

    // Assemble the on-wire word: write flag, address, data, MSB first.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                       input logic [DATA_W-1:0] data);
        return {WRITE_BIT, addr, data};
    endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Frame datapath: shift register, bit counter and SCLK half-period divider.
// Sequencing is owned by the scheduler FSM, which drives load/run/shift.
module spi_frame_tx
    import spi_write_scheduler_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    input  logic               run,
    input  logic               shift,
    output logic               div_done,
    output logic               frame_end,
    output logic               msb
);

    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [4:0]         bit_q, bit_d;
    logic [7:0]         div_q, div_d;

    assign div_done  = (div_q == 8'(CLK_DIV - 1));
    // bit_q counts falling SCLK edges; 16 means every bit has been presented.
    assign frame_end = (bit_q == 5'(FRAME_W));
    assign msb       = shreg_q[FRAME_W-1];

    // Next-state for shift register, bit counter and phase divider.
    always_comb begin
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        if (load) begin
            shreg_d = frame;
            bit_d   = '0;
            div_d   = '0;
        end else begin
            if (run) begin
                div_d = div_done ? 8'd0 : div_q + 8'd1;
            end else begin
                div_d = '0;
            end
            if (shift) begin
                shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                bit_d   = bit_q + 5'd1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
        end
    end

endmodule

// File: rtl/spi_write_scheduler.sv
// Two-requester SPI register-write scheduler with round-robin arbitration.
// Optional build macro WRITE_SHADOW_EN keeps a shadow copy of registers 0..4
// and suppresses writes that would not change the target value.
module spi_write_scheduler
    import spi_write_scheduler_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              cs_n,
    output logic              sclk,
    output logic              copi,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // The IDLE accept cycle is the last cycle of the inter-frame gap, so the
    // GAP state itself only needs CS_GAP-1 cycles (none when CS_GAP is 1).
    localparam state_e     AfterFrame = (CS_GAP > 1) ? StGap : StIdle;
    localparam logic [7:0] GapLoad    = 8'((CS_GAP > 1) ? CS_GAP - 2 : 0);

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              armed_q;
    logic [7:0]        gap_q, gap_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              grant0, grant1, accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              illegal, skip;
    logic              in_frame, frame_fin;
    logic              tx_load, tx_shift, div_done, frame_end, tx_msb;

    // ptr_q set means req1 has priority on a tie.
    assign grant0   = req0_valid & (~req1_valid | ~ptr_q);
    assign grant1   = req1_valid & (~req0_valid | ptr_q);
    // armed_q holds off grants until the first edge after reset release.
    assign accept   = armed_q & (state_q == StIdle) & (req0_valid | req1_valid);
    assign sel_addr = grant0 ? req0_addr : req1_addr;
    assign sel_data = grant0 ? req0_data : req1_data;
    assign illegal  = (sel_addr > MAX_ADDR);

    assign in_frame  = (state_q == StSetup) | (state_q == StShiftHi) | (state_q == StShiftLo);
    assign frame_fin = (state_q == StShiftLo) & div_done & frame_end;

    assign req0_ready = accept & grant0;
    assign req1_ready = accept & grant1;
    assign cs_n       = ~in_frame;
    assign sclk       = (state_q == StShiftHi);
    assign copi       = in_frame & tx_msb;
    assign busy       = (state_q != StIdle) | accept;
    assign done       = done_q;
    assign err        = err_q;

`ifdef WRITE_SHADOW_EN
    logic [DATA_W-1:0] shadow_q [NUM_SHADOW];
    logic [2:0]        pend_addr_q;
    logic [DATA_W-1:0] pend_data_q;

    assign skip = ~illegal & (shadow_q[sel_addr[2:0]] == sel_data);

    // Remember the in-flight write so the shadow updates only when it completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else if (tx_load) begin
            pend_addr_q <= sel_addr[2:0];
            pend_data_q <= sel_data;
        end
    end

    // Shadow copy of registers 0..4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SHADOW; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (frame_fin) begin
            shadow_q[pend_addr_q] <= pend_data_q;
        end
    end
`else
    assign skip = 1'b0;
`endif

    // Frame sequencing: accept, setup, 16 SCLK periods, then gap.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        ptr_d    = ptr_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tx_load  = 1'b0;
        tx_shift = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    ptr_d = grant0;
                    if (illegal || skip) begin
                        done_d  = 1'b1;
                        err_d   = illegal;
                        state_d = AfterFrame;
                        gap_d   = GapLoad;
                    end else begin
                        tx_load = 1'b1;
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                if (div_done) begin
                    state_d = StShiftHi;
                end
            end
            StShiftHi: begin
                if (div_done) begin
                    state_d  = StShiftLo;
                    tx_shift = 1'b1;
                end
            end
            StShiftLo: begin
                if (div_done) begin
                    if (frame_end) begin
                        done_d  = 1'b1;
                        state_d = AfterFrame;
                        gap_d   = GapLoad;
                    end else begin
                        state_d = StShiftHi;
                    end
                end
            end
            StGap: begin
                if (gap_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            armed_q <= 1'b0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            armed_q <= 1'b1;
            gap_q   <= gap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    spi_frame_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_frame_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load),
        .frame     (build_frame(sel_addr, sel_data)),
        .run       (in_frame),
        .shift     (tx_shift),
        .div_done  (div_done),
        .frame_end (frame_end),
        .msb       (tx_msb)
    );

endmodule

// File: tb/tb_spi_write_scheduler.sv
// Directed self-checking bench for spi_write_scheduler (CLK_DIV=2, CS_GAP=3).
module tb_spi_write_scheduler;

`ifdef WRITE_SHADOW_EN
    localparam logic SHADOW = 1'b1;
`else
    localparam logic SHADOW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [6:0] req0_addr = '0, req1_addr = '0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic       req0_ready, req1_ready, cs_n, sclk, copi, busy, done, err;

    int n_cmp = 0;
    int n_err = 0;

    spi_write_scheduler #(
        .CLK_DIV (2),
        .CS_GAP  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .cs_n       (cs_n),
        .sclk       (sclk),
        .copi       (copi),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Bus monitor, sampled on the falling edge.
    int          mon_low = 0, mon_done = 0, mon_err = 0, mon_r0 = 0, mon_r1 = 0;
    int          mon_overlap = 0, mon_bad = 0, mon_frames = 0, mon_high = 0, mon_gap = 0;
    logic [15:0] mon_bits = '0;
    logic        prev_cs_n = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;

    always @(negedge clk) begin
        if (!cs_n) mon_low <= mon_low + 1;
        if (!cs_n && sclk && !prev_sclk) mon_bits <= {mon_bits[14:0], copi};
        if (!cs_n && !prev_cs_n && (copi !== prev_copi) && !(prev_sclk && !sclk))
            mon_bad <= mon_bad + 1;
        if (!cs_n && prev_cs_n) begin
            mon_frames <= mon_frames + 1;
            mon_gap    <= mon_high;
        end
        mon_high <= cs_n ? mon_high + 1 : 0;
        if (done) mon_done <= mon_done + 1;
        if (err) mon_err <= mon_err + 1;
        if (req0_ready) mon_r0 <= mon_r0 + 1;
        if (req1_ready) mon_r1 <= mon_r1 + 1;
        if (req0_ready && req1_ready) mon_overlap <= mon_overlap + 1;
        prev_cs_n <= cs_n;
        prev_sclk <= sclk;
        prev_copi <= copi;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller is just after a rising edge; returns just after the capture edge.
    task automatic issue(input int port, input logic [6:0] a, input logic [7:0] d,
                         input string tag);
        logic seen;
        seen = 1'b0;
        if (port == 0) begin
            req0_valid = 1'b1; req0_addr = a; req0_data = d;
        end else begin
            req1_valid = 1'b1; req1_addr = a; req1_data = d;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((port == 0) ? req0_ready : req1_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_ready"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data  = 8'hFF; req1_data = 8'hFF;
        req0_addr  = 7'h7F; req1_addr = 7'h7F;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_idle_seen"}, 32'(seen), 32'd1);
    endtask

    int s_low, s_done, s_err, s_frames, s_r0, s_r1, s_bad;

    task automatic snap();
        s_low = mon_low; s_done = mon_done; s_err = mon_err; s_frames = mon_frames;
        s_r0 = mon_r0; s_r1 = mon_r1; s_bad = mon_bad;
    endtask

    initial begin
        // Reset state, with a request already pending.
        req0_valid = 1'b1; req0_addr = 7'h02; req0_data = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs_n", 32'(cs_n), 32'd1);
        check_eq("rst_sclk", 32'(sclk), 32'd0);
        check_eq("rst_copi", 32'(copi), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done_err", 32'({done, err}), 32'd0);
        check_eq("rst_ready", 32'(req0_ready), 32'd0);
        snap();
        rst = 1'b1;

        // Basic frame: addr 0x02 data 0xA5 -> 0x82A5, 66 low cycles.
        @(negedge clk);
        check_eq("first_edge_ready", 32'(req0_ready), 32'd0);
        @(negedge clk);
        check_eq("basic_ready", 32'(req0_ready), 32'd1);
        check_eq("basic_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_data = 8'hFF;
        @(negedge clk);
        check_eq("basic_cs_low", 32'(cs_n), 32'd0);
        check_eq("basic_copi_b15", 32'(copi), 32'd1);
        check_eq("basic_sclk_setup", 32'(sclk), 32'd0);
        wait_done("basic");
        check_eq("basic_bits", 32'(mon_bits), 32'h82A5);
        check_eq("basic_low", 32'(mon_low - s_low), 32'd66);
        wait_idle("basic");
        check_eq("basic_dones", 32'(mon_done - s_done), 32'd1);
        check_eq("basic_err", 32'(mon_err - s_err), 32'd0);
        check_eq("basic_copi_stable", 32'(mon_bad - s_bad), 32'd0);

        // Tie from reset: req0 first, req1 second, back-to-back gap of 3.
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("tie_rst_cs_n", 32'(cs_n), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        snap();
        req0_valid = 1'b1; req0_addr = 7'h01; req0_data = 8'h3C;
        req1_valid = 1'b1; req1_addr = 7'h03; req1_data = 8'hC3;
        @(negedge clk);
        check_eq("tie_first_edge", 32'(req0_ready | req1_ready), 32'd0);
        @(negedge clk);
        check_eq("tie_r0_first", 32'(req0_ready), 32'd1);
        check_eq("tie_r1_held", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_data = 8'h00;
        wait_done("tie_a");
        check_eq("tie_a_bits", 32'(mon_bits), 32'h813C);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (req1_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            check_eq("tie_r1_seen", 32'(seen), 32'd1);
            check_eq("tie_r0_quiet", 32'(req0_ready), 32'd0);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0; req1_data = 8'h00;
        wait_done("tie_b");
        check_eq("tie_b_bits", 32'(mon_bits), 32'h83C3);
        check_eq("tie_gap", 32'(mon_gap), 32'd3);
        wait_idle("tie");
        check_eq("tie_r0_count", 32'(mon_r0 - s_r0), 32'd1);
        check_eq("tie_r1_count", 32'(mon_r1 - s_r1), 32'd1);
        check_eq("tie_overlap", 32'(mon_overlap), 32'd0);
        check_eq("tie_dones", 32'(mon_done - s_done), 32'd2);

        // Illegal address: accepted, err+done, no frame.
        snap();
        issue(0, 7'h07, 8'h11, "ill");
        check_eq("ill_err", 32'(err), 32'd1);
        check_eq("ill_done", 32'(done), 32'd1);
        check_eq("ill_cs_n", 32'(cs_n), 32'd1);
        @(posedge clk); #1;
        check_eq("ill_pulse_end", 32'({err, done}), 32'd0);
        wait_idle("ill");
        check_eq("ill_frames", 32'(mon_frames - s_frames), 32'd0);
        check_eq("ill_low", 32'(mon_low - s_low), 32'd0);

        // Reset during bit 9 (SCLK high, copi=1), then a clean frame.
        issue(0, 7'h04, 8'h5A, "abort");
        repeat (38) @(posedge clk);
        #2;
        check_eq("abort_pre_cs", 32'(cs_n), 32'd0);
        check_eq("abort_pre_sclk", 32'(sclk), 32'd1);
        check_eq("abort_pre_copi", 32'(copi), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("abort_cs_n", 32'(cs_n), 32'd1);
        check_eq("abort_sclk", 32'(sclk), 32'd0);
        check_eq("abort_copi_busy", 32'({copi, busy}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        snap();
        issue(1, 7'h00, 8'h96, "after");
        wait_done("after");
        check_eq("after_bits", 32'(mon_bits), 32'h8096);
        check_eq("after_low", 32'(mon_low - s_low), 32'd66);
        wait_idle("after");

        // Same write twice: the shadow build suppresses the second frame.
        snap();
        issue(0, 7'h04, 8'h80, "shd_a");
        wait_done("shd_a");
        check_eq("shd_a_bits", 32'(mon_bits), 32'h8480);
        wait_idle("shd_a");
        issue(0, 7'h04, 8'h80, "shd_b");
        check_eq("shd_b_done", 32'(done), 32'(SHADOW));
        check_eq("shd_b_cs_n", 32'(cs_n), 32'(SHADOW));
        check_eq("shd_b_err", 32'(err), 32'd0);
        wait_idle("shd_b");
        check_eq("shd_frames", 32'(mon_frames - s_frames), SHADOW ? 32'd1 : 32'd2);
        check_eq("shd_dones", 32'(mon_done - s_done), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
